// File: rtl/sort_floats_serial.sv
// rtl/sort_floats_serial.sv - serial three-value float sorter with one shared comparator

package sort_floats_pkg;
    localparam int FLEN = 64;
endpackage

// IEEE-754 less-or-equal; NaN operands report err and compare as not-less-or-equal
module f_less_or_equal
    import sort_floats_pkg::*;
(
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            le,
    output logic            err
);
    localparam int EW = (FLEN == 32) ? 8 : 11;
    localparam int MW = FLEN - 1 - EW;

    logic a_nan;
    logic b_nan;
    logic a_zero;
    logic b_zero;
    logic a_sign;
    logic b_sign;
    logic [FLEN-2:0] a_mag;
    logic [FLEN-2:0] b_mag;

    assign a_sign = a[FLEN-1];
    assign b_sign = b[FLEN-1];
    assign a_mag  = a[FLEN-2:0];
    assign b_mag  = b[FLEN-2:0];
    assign a_nan  = (&a[FLEN-2 -: EW]) && (|a[MW-1:0]);
    assign b_nan  = (&b[FLEN-2 -: EW]) && (|b[MW-1:0]);
    assign a_zero = ~|a_mag;
    assign b_zero = ~|b_mag;

    // Sign/magnitude ordering; the bit pattern of a magnitude is monotonic in its value
    always_comb begin
        le  = 1'b0;
        err = 1'b0;
        if (a_nan || b_nan) begin
            err = 1'b1;
        end else if (a_zero && b_zero) begin
            le = 1'b1;
        end else if (a_sign != b_sign) begin
            le = a_sign;
        end else if (!a_sign) begin
            le = (a_mag <= b_mag);
        end else begin
            le = (a_mag >= b_mag);
        end
    end
endmodule

module sort_floats_serial
    import sort_floats_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            arg_vld,
    input  logic [FLEN-1:0] arg,
    output logic            arg_rdy,
    output logic            res_vld,
    output logic [FLEN-1:0] res,
    output logic            res_last,
    input  logic            res_rdy,
    output logic            err
);
    typedef enum logic [1:0] {COLLECT, SORT, OUT} state_t;

    state_t          state_q;
    state_t          state_d;
    logic            run_q;
    logic [1:0]      cnt_q;
    logic [1:0]      step_q;
    logic [1:0]      idx_q;
    logic            err_q;
    logic [FLEN-1:0] b0_q;
    logic [FLEN-1:0] b1_q;
    logic [FLEN-1:0] b2_q;
    logic [FLEN-1:0] cmp_a;
    logic [FLEN-1:0] cmp_b;
    logic            cmp_le;
    logic            cmp_err;

    // Step 1 looks at the upper pair, steps 0 and 2 at the lower pair
    assign cmp_a = (step_q == 2'd1) ? b1_q : b0_q;
    assign cmp_b = (step_q == 2'd1) ? b2_q : b1_q;

    f_less_or_equal u_cmp (
        .a   (cmp_a),
        .b   (cmp_b),
        .le  (cmp_le),
        .err (cmp_err)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Keeps arg_rdy low until the first clock after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Next state and outputs, all derived from registered state
    always_comb begin
        state_d  = state_q;
        arg_rdy  = 1'b0;
        res_vld  = 1'b0;
        res      = '0;
        res_last = 1'b0;
        err      = 1'b0;
        case (state_q)
            COLLECT: begin
                arg_rdy = run_q;
                if (arg_vld && run_q && cnt_q == 2'd2) begin
                    state_d = SORT;
                end
            end
            SORT: begin
                if (step_q == 2'd2) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                res_vld  = 1'b1;
                res_last = (idx_q == 2'd2);
                err      = err_q;
                case (idx_q)
                    2'd0:    res = b0_q;
                    2'd1:    res = b1_q;
                    default: res = b2_q;
                endcase
                if (res_rdy && idx_q == 2'd2) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Buffer fill, in-place compare-swap steps and output index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 2'd0;
            step_q <= 2'd0;
            idx_q  <= 2'd0;
            err_q  <= 1'b0;
            b0_q   <= '0;
            b1_q   <= '0;
            b2_q   <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (arg_vld && arg_rdy) begin
                        case (cnt_q)
                            2'd0:    b0_q <= arg;
                            2'd1:    b1_q <= arg;
                            default: b2_q <= arg;
                        endcase
                        if (cnt_q == 2'd2) begin
                            cnt_q  <= 2'd0;
                            step_q <= 2'd0;
                            idx_q  <= 2'd0;
                            err_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                SORT: begin
                    err_q  <= err_q | cmp_err;
                    step_q <= step_q + 2'd1;
                    if (!cmp_le) begin
                        if (step_q == 2'd1) begin
                            b1_q <= b2_q;
                            b2_q <= b1_q;
                        end else begin
                            b0_q <= b1_q;
                            b1_q <= b0_q;
                        end
                    end
                    if (step_q == 2'd2) begin
                        idx_q <= 2'd0;
                    end
                end
                OUT: begin
                    if (res_rdy) begin
                        idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_floats_serial.sv
// tb/tb_sort_floats_serial.sv - scoreboard bench for sort_floats_serial

module tb_sort_floats_serial;
    import sort_floats_pkg::*;

    typedef struct {
        logic [63:0] d;
        logic        last;
        logic        err;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            arg_vld = 1'b0;
    logic [FLEN-1:0] arg = '0;
    logic            arg_rdy;
    logic            res_vld;
    logic [FLEN-1:0] res;
    logic            res_last;
    logic            res_rdy = 1'b1;
    logic            err;

    int    checks = 0;
    int    fails = 0;
    beat_t exp_q[$];

    localparam logic [63:0] P0   = 64'h0000000000000000;
    localparam logic [63:0] N0   = 64'h8000000000000000;
    localparam logic [63:0] ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] TWO  = 64'h4000000000000000;
    localparam logic [63:0] THR  = 64'h4008000000000000;
    localparam logic [63:0] PINF = 64'h7FF0000000000000;
    localparam logic [63:0] NONE = 64'hBFF0000000000000;
    localparam logic [63:0] QNAN = 64'h7FF8000000000000;

    sort_floats_serial dut (
        .clk      (clk),
        .rst      (rst),
        .arg_vld  (arg_vld),
        .arg      (arg),
        .arg_rdy  (arg_rdy),
        .res_vld  (res_vld),
        .res      (res),
        .res_last (res_last),
        .res_rdy  (res_rdy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    function automatic logic le_model(input logic [63:0] x, input logic [63:0] y);
        if (is_nan(x) || is_nan(y)) return 1'b0;
        return ($bitstoreal(x) <= $bitstoreal(y));
    endfunction

    task automatic push_triple(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        logic [63:0] v [3];
        logic [63:0] t;
        logic        e;
        int          pi [3];
        beat_t       bt;
        v[0] = a; v[1] = b; v[2] = c;
        pi[0] = 0; pi[1] = 1; pi[2] = 0;
        e = 1'b0;
        for (int s = 0; s < 3; s++) begin
            e = e | is_nan(v[pi[s]]) | is_nan(v[pi[s]+1]);
            if (!le_model(v[pi[s]], v[pi[s]+1])) begin
                t = v[pi[s]];
                v[pi[s]] = v[pi[s]+1];
                v[pi[s]+1] = t;
            end
        end
        for (int k = 0; k < 3; k++) begin
            bt.d = v[k];
            bt.last = (k == 2);
            bt.err = e;
            exp_q.push_back(bt);
        end
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge
    task automatic send_beat(input logic [63:0] x);
        int t;
        t = 0;
        arg_vld = 1'b1;
        arg = x;
        while (!arg_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("arg_rdy_wait", {63'd0, arg_rdy}, 64'd1);
        @(negedge clk);
        arg_vld = 1'b0;
    endtask

    task automatic send_triple(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                               input logic do_push);
        if (do_push) push_triple(a, b, c);
        send_beat(a);
        send_beat(b);
        send_beat(c);
    endtask

    task automatic recv_triple(input logic bp);
        int          t;
        beat_t       e;
        logic [63:0] r0;
        logic        l0;
        logic        e0;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (!res_vld && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("res_vld_wait", {63'd0, res_vld}, 64'd1);
            if (bp) begin
                res_rdy = 1'b0;
                r0 = res; l0 = res_last; e0 = err;
                for (int w = 0; w < 5; w++) begin
                    @(negedge clk);
                    check("bp_res", res, r0);
                    check("bp_last", {63'd0, res_last}, {63'd0, l0});
                    check("bp_err", {63'd0, err}, {63'd0, e0});
                    check("bp_vld", {63'd0, res_vld}, 64'd1);
                    check("bp_arg_rdy", {63'd0, arg_rdy}, 64'd0);
                end
                res_rdy = 1'b1;
            end
            check("out_arg_rdy", {63'd0, arg_rdy}, 64'd0);
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("res", res, e.d);
                check("res_last", {63'd0, res_last}, {63'd0, e.last});
                check("err", {63'd0, err}, {63'd0, e.err});
            end
            @(negedge clk);
        end
        check("arg_rdy_after_out", {63'd0, arg_rdy}, 64'd1);
    endtask

    initial begin
        // reset values
        #2;
        check("rst_arg_rdy", {63'd0, arg_rdy}, 64'd0);
        check("rst_res_vld", {63'd0, res_vld}, 64'd0);
        check("rst_res_last", {63'd0, res_last}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_res", res, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_arg_rdy", {63'd0, arg_rdy}, 64'd1);

        // basic sort with latency
        send_triple(THR, ONE, TWO, 1'b1);
        check("lat_e0", {63'd0, res_vld}, 64'd0);
        @(negedge clk);
        check("lat_e1", {63'd0, res_vld}, 64'd0);
        @(negedge clk);
        check("lat_e2", {63'd0, res_vld}, 64'd0);
        @(negedge clk);
        check("lat_e3", {63'd0, res_vld}, 64'd1);
        recv_triple(1'b0);

        // reverse order and signs
        send_triple(PINF, P0, NONE, 1'b1);
        recv_triple(1'b0);

        // signed zeros keep input order
        send_triple(N0, P0, N0, 1'b1);
        recv_triple(1'b0);

        // NaN flags all beats; next triple is clean
        send_triple(ONE, QNAN, TWO, 1'b1);
        recv_triple(1'b0);
        send_triple(TWO, ONE, THR, 1'b1);
        recv_triple(1'b0);

        // backpressure
        send_triple(THR, TWO, ONE, 1'b1);
        recv_triple(1'b1);

        // async reset during SORT
        send_triple(TWO, ONE, THR, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check("arst_res_vld", {63'd0, res_vld}, 64'd0);
        check("arst_arg_rdy", {63'd0, arg_rdy}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("arst_release_arg_rdy", {63'd0, arg_rdy}, 64'd1);
        send_triple(THR, TWO, ONE, 1'b1);
        recv_triple(1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_leftover", {63'd0, res_vld}, 64'd0);
        end
        check("queue_drained", exp_q.size(), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
